io_trace_recorder: RTL and testbench

IO_TRACE_RECORDER -- requirements
Module: io_trace_recorder

---
 rtl/io_trace_recorder.sv | 186 ++++++++++++++++++
 tb/tb_io_trace_recorder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_trace_recorder.sv
// Purpose : capture-and-replay trace recorder; samples a signal bundle into a FIFO with
//           cycle timestamps and closes each session with a marker record.
// Latency : first-word fall-through; a record written at edge N is visible after edge N.
// Backpressure: out_valid/out_ready; records wait in the FIFO, a full FIFO with no pop
//           drops the sample, counts the drop and sets the sticky overflow flag.
//
// Ports:
//   clock      - single clock, all state on its rising edge
//   reset      - synchronous, active-high
//   trace_en   - capture session enable
//   sample_in  - DATA_WIDTH signal bundle sampled every edge
//   out_valid  - record available (never a function of out_ready)
//   out_ready  - host accepts the presented record
//   out_bits   - {timestamp, data}; marker is {cycle count, drop count}
//   out_last   - presented record is the end-of-session marker
//   overflow   - sticky, at least one sample dropped this session
//   busy       - session in RECORD or DRAIN
//
// Build option: define TRACE_DELTA_EN to record only samples that differ from the last
// pushed one (the first sample of a session is always recorded).

module io_trace_recorder #(
    parameter int DATA_WIDTH  = 64,
    parameter int CYCLE_WIDTH = 32,
    parameter int DEPTH       = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              trace_en,
    input  logic [DATA_WIDTH-1:0]             sample_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CYCLE_WIDTH+DATA_WIDTH-1:0] out_bits,
    output logic                              out_last,
    output logic                              overflow,
    output logic                              busy
);

    localparam int RW = CYCLE_WIDTH + DATA_WIDTH;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]          PTR_ONE = 1;
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [RW-1:0]          mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic [CYCLE_WIDTH-1:0] cyc_q;
    logic [CYCLE_WIDTH-1:0] drop_q;
    logic                   ovf_q;
    logic                   busy_q;
    logic                   last_q;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic                   start;
    logic                   sampling;
    logic                   want_push;
    logic                   push;
    logic                   drop;
    logic [CYCLE_WIDTH-1:0] stamp;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // The edge that sees trace_en high in IDLE is the session's first sample and
    // carries timestamp 0; the counter is loaded with 1 for the following cycle.
    assign start    = (state_q == ST_IDLE) && trace_en;
    assign sampling = start || ((state_q == ST_RECORD) && trace_en);
    assign stamp    = start ? '0 : cyc_q;

`ifdef TRACE_DELTA_EN
    // Last sample actually written; a dropped change stays "different" and is
    // retried on the next cycle.
    logic [DATA_WIDTH-1:0] prev_q;

    assign want_push = sampling && (start || (sample_in != prev_q));

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
        end else if (push) begin
            prev_q <= sample_in;
        end
    end
`else
    assign want_push = sampling;
`endif

    // The FIFO is empty in END and IDLE, so a pop only happens on real records.
    assign fifo_pop = !fifo_empty && out_ready;
    assign push     = want_push && (!fifo_full || fifo_pop);
    assign drop     = want_push && fifo_full && !fifo_pop;

    assign out_valid = last_q || !fifo_empty;
    assign out_last  = last_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

    always_comb begin
        out_bits = '0;
        if (last_q) begin
            out_bits = {cyc_q, DATA_WIDTH'(drop_q)};
        end else if (!fifo_empty) begin
            out_bits = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Storage carries no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {stamp, sample_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cyc_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (trace_en) begin
                        state_q <= ST_RECORD;
                        busy_q  <= 1'b1;
                        cyc_q   <= CYC_ONE;
                        drop_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_RECORD: begin
                    if (trace_en) begin
                        cyc_q <= cyc_q + CYC_ONE;
                        if (drop) begin
                            ovf_q <= 1'b1;
                            if (drop_q != '1) begin
                                drop_q <= drop_q + CYC_ONE;
                            end
                        end
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ST_END;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b1;
                    end
                end
                ST_END: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_trace_recorder.sv
module tb_io_trace_recorder;

    localparam int DW = 64;
    localparam int CW = 32;
    localparam int DEPTH = 16;
    localparam int RW = CW + DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          trace_en;
    logic [DW-1:0] sample_in;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_bits;
    logic          out_last;
    logic          overflow;
    logic          busy;

    io_trace_recorder #(.DATA_WIDTH(DW), .CYCLE_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .trace_en  (trace_en),
        .sample_in (sample_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: session phase plus the list of records still owed to the host.
    localparam int P_IDLE = 0, P_REC = 1, P_DRAIN = 2, P_END = 3;
    int            m_phase;
    logic [RW-1:0] m_q[$];
    logic [CW-1:0] m_cyc;
    logic [CW-1:0] m_drop;
    logic          m_ovf;
    logic [DW-1:0] m_last;

    logic [RW-1:0] got[$];
    logic          saw_last;

    task automatic model_step(input logic rst, input logic te, input logic [DW-1:0] s,
                              input logic rdy);
        int   sz;
        logic pop;
        logic want;
        if (rst) begin
            m_q.delete();
            m_phase = P_IDLE;
            m_cyc = '0;
            m_drop = '0;
            m_ovf = 1'b0;
            m_last = '0;
            return;
        end
        sz  = m_q.size();
        pop = rdy && (sz > 0);
        if (pop) void'(m_q.pop_front());
        case (m_phase)
            P_IDLE: if (te) begin
                m_phase = P_REC;
                m_q.push_back({CW'(0), s});
                m_last = s;
                m_cyc = 1;
                m_drop = '0;
                m_ovf = 1'b0;
            end
            P_REC: if (!te) begin
                m_phase = P_DRAIN;
            end else begin
                want = 1'b1;
`ifdef TRACE_DELTA_EN
                want = (s != m_last);
`endif
                if (want) begin
                    if (sz < DEPTH || pop) begin
                        m_q.push_back({m_cyc, s});
                        m_last = s;
                    end else begin
                        if (m_drop != '1) m_drop = m_drop + 1;
                        m_ovf = 1'b1;
                    end
                end
                m_cyc = m_cyc + 1;
            end
            P_DRAIN: if (sz == 0) m_phase = P_END;
            default: if (rdy) m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_model();
        logic          ev;
        logic [RW-1:0] eb;
        ev = (m_phase == P_END) || (m_q.size() > 0);
        if (m_phase == P_END) eb = {m_cyc, DW'(m_drop)};
        else if (m_q.size() > 0) eb = m_q[0];
        else eb = '0;
        chk("model out_valid", out_valid, ev);
        chk("model out_bits", out_bits, eb);
        chk("model out_last", out_last, m_phase == P_END);
        chk("model busy", busy, (m_phase == P_REC) || (m_phase == P_DRAIN));
        chk("model overflow", overflow, m_ovf);
    endtask

    // One clock: drive at posedge+1, note any handshake, advance model, check at posedge+1.
    task automatic tick(input logic rst, input logic te, input logic [DW-1:0] s,
                        input logic rdy);
        reset = rst;
        trace_en = te;
        sample_in = s;
        out_ready = rdy;
        #1;
        if (!rst && out_valid && out_ready) begin
            got.push_back(out_bits);
            if (out_last) saw_last = 1'b1;
        end
        model_step(rst, te, s, rdy);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, 1'b0);
        got.delete();
        saw_last = 1'b0;
    endtask

    task automatic drain_session();
        saw_last = 1'b0;
        for (int i = 0; i < 200 && !saw_last; i++) tick(1'b0, 1'b0, '0, 1'b1);
        chk("drain reaches marker", saw_last, 1'b1);
    endtask

    typedef struct {
        logic          te;
        logic [DW-1:0] s;
        logic          rdy;
        logic          ev;
        logic [RW-1:0] eb;
        logic          el;
        logic          ebusy;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [RW-1:0] held;
        reset = 1'b1;
        trace_en = 1'b0;
        sample_in = '0;
        out_ready = 1'b0;
        saw_last = 1'b0;
        model_step(1'b1, 1'b0, '0, 1'b0);
        @(posedge clock);
        #1;
        do_reset();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_bits", out_bits, '0);
        chk("reset busy", busy, 1'b0);

        // Five-sample session with the host always ready.
        vt[0] = '{1'b1, 64'h10, 1'b1, 1'b1, {32'd0, 64'h10}, 1'b0, 1'b1};
        vt[1] = '{1'b1, 64'h11, 1'b1, 1'b1, {32'd1, 64'h11}, 1'b0, 1'b1};
        vt[2] = '{1'b1, 64'h12, 1'b1, 1'b1, {32'd2, 64'h12}, 1'b0, 1'b1};
        vt[3] = '{1'b1, 64'h13, 1'b1, 1'b1, {32'd3, 64'h13}, 1'b0, 1'b1};
        vt[4] = '{1'b1, 64'h14, 1'b1, 1'b1, {32'd4, 64'h14}, 1'b0, 1'b1};
        vt[5] = '{1'b0, 64'h0,  1'b1, 1'b0, '0,              1'b0, 1'b1};
        vt[6] = '{1'b0, 64'h0,  1'b1, 1'b1, {32'd5, 64'h0},  1'b1, 1'b0};
        vt[7] = '{1'b0, 64'h0,  1'b1, 1'b0, '0,              1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, vt[i].te, vt[i].s, vt[i].rdy);
            chk($sformatf("vec%0d out_valid", i), out_valid, vt[i].ev);
            chk($sformatf("vec%0d out_bits", i), out_bits, vt[i].eb);
            chk($sformatf("vec%0d out_last", i), out_last, vt[i].el);
            chk($sformatf("vec%0d busy", i), busy, vt[i].ebusy);
        end

        // Overflow: 20 samples into 16 entries with the host stalled.
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, DW'(i + 1), 1'b0);
        chk("ovf flag set", overflow, 1'b1);
        drain_session();
        chk("ovf record count", got.size(), 17);
        for (int k = 0; k < 16 && k < got.size(); k++)
            chk($sformatf("ovf stamp %0d", k), got[k][RW-1:DW], k);
        if (got.size() == 17) chk("ovf marker", got[16], {32'd20, 64'd4});
        chk("ovf sticky after end", overflow, 1'b1);

        // Full FIFO with a pop every cycle never drops.
        do_reset();
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, DW'(i), 1'b0);
        for (int i = 16; i < 26; i++) tick(1'b0, 1'b1, DW'(i), 1'b1);
        drain_session();
        chk("full+pop overflow", overflow, 1'b0);
        chk("full+pop count", got.size(), 27);
        for (int k = 0; k < 26 && k < got.size(); k++)
            chk($sformatf("full+pop stamp %0d", k), got[k][RW-1:DW], k);
        if (got.size() == 27) chk("full+pop marker", got[26], {32'd26, 64'd0});

        // Stall: presented record stays put and transfers once.
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, DW'(8'hA0 + i), 1'b0);
        held = out_bits;
        chk("stall head", held, {32'd0, 64'hA0});
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            chk($sformatf("stall hold %0d", i), out_bits, held);
            chk($sformatf("stall valid %0d", i), out_valid, 1'b1);
        end
        drain_session();
        chk("stall count", got.size(), 4);
        if (got.size() == 4) begin
            chk("stall once", got[0], held);
            chk("stall next", got[1], {32'd1, 64'hA1});
        end

        // Reset in DRAIN with 8 records queued.
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, DW'(i), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("pre-reset busy", busy, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("mid reset out_valid", out_valid, 1'b0);
        chk("mid reset busy", busy, 1'b0);
        chk("mid reset out_bits", out_bits, '0);
        tick(1'b0, 1'b1, 64'hAB, 1'b0);
        chk("restart stamp", out_bits, {32'd0, 64'hAB});
        tick(1'b0, 1'b0, '0, 1'b0);
        drain_session();

`ifdef TRACE_DELTA_EN
        do_reset();
        tick(1'b0, 1'b1, 64'hA, 1'b0);
        tick(1'b0, 1'b1, 64'hA, 1'b0);
        tick(1'b0, 1'b1, 64'hA, 1'b0);
        tick(1'b0, 1'b1, 64'hB, 1'b0);
        tick(1'b0, 1'b1, 64'hB, 1'b0);
        drain_session();
        chk("delta count", got.size(), 3);
        if (got.size() == 3) begin
            chk("delta rec0", got[0], {32'd0, 64'hA});
            chk("delta rec1", got[1], {32'd3, 64'hB});
            chk("delta marker", got[2], {32'd5, 64'd0});
        end
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            int te_pct;
            rdy_pct = $urandom_range(10, 100);
            te_pct  = $urandom_range(30, 95);
            for (int c = 0; c < 200; c++) begin
                tick($urandom_range(0, 299) == 0,
                     $urandom_range(1, 100) <= te_pct,
                     DW'($urandom_range(0, 3)),
                     $urandom_range(1, 100) <= rdy_pct);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
